// File: rtl/apb_master_ctrl_param.sv
// ----------------------------------------------------------------------------
// apb_master_ctrl_param
//
// APB master controller for the AHB2APB bridge. Takes a decoded AHB-side
// request (address, direction, one-hot slave select) and runs the APB
// SETUP/ACCESS phases for it. Supports PREADY wait states and PSLVERR. A bad
// select or a slave error is reported to AHB as a two-cycle ERROR response.
//
// Optional feature (compile-time macro APB_TIMEOUT_EN):
//   When defined, an ACCESS phase that sees Pready=0 for MAX_WAIT cycles is
//   aborted and reported as an ERROR response. When undefined, ACCESS waits
//   for Pready indefinitely and MAX_WAIT is unused.
//
// Parameters:
//   ADDR_W   - address width (Haddr, Paddr)
//   DATA_W   - data width (Hwdata, Hrdata, Pwdata, Prdata)
//   NUM_SLV  - number of APB slaves (slv_sel, Pselx)
//   MAX_WAIT - ACCESS cycles with Pready=0 before abort (APB_TIMEOUT_EN only)
//
// Ports:
//   Hclk, Hreset        clock, asynchronous active-high reset
//   valid, Hwrite,
//   Haddr, slv_sel      AHB request, sampled when a transfer is accepted
//   Hwdata              write data, one cycle after the address is accepted
//   Hreadyout, Hresp,
//   Hrdata              AHB response
//   Pselx, Penable,
//   Pwrite, Paddr,
//   Pwdata              APB request
//   Prdata, Pready,
//   Pslverr             APB response (only looked at during ACCESS)
//
// Every output comes from a flop; there is no input-to-output combinational
// path.
// ----------------------------------------------------------------------------
module apb_master_ctrl_param #(
   parameter int ADDR_W   = 32,
   parameter int DATA_W   = 32,
   parameter int NUM_SLV  = 3,
   parameter int MAX_WAIT = 16
) (
   input  logic               Hclk,
   input  logic               Hreset,
   input  logic               valid,
   input  logic               Hwrite,
   input  logic [ADDR_W-1:0]  Haddr,
   input  logic [NUM_SLV-1:0] slv_sel,
   input  logic [DATA_W-1:0]  Hwdata,
   output logic               Hreadyout,
   output logic               Hresp,
   output logic [DATA_W-1:0]  Hrdata,
   output logic [NUM_SLV-1:0] Pselx,
   output logic               Penable,
   output logic               Pwrite,
   output logic [ADDR_W-1:0]  Paddr,
   output logic [DATA_W-1:0]  Pwdata,
   input  logic [DATA_W-1:0]  Prdata,
   input  logic               Pready,
   input  logic               Pslverr
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      WDATA  = 3'd1,
      SETUP  = 3'd2,
      ACCESS = 3'd3,
      ERR1   = 3'd4,
      ERR2   = 3'd5
   } state_t;

   state_t               state_r;
   state_t               next_state_s;
   logic                 accept_s;
   logic                 timeout_s;
   logic                 apb_next_s;
   logic [NUM_SLV-1:0]   sel_r;
   logic [NUM_SLV-1:0]   sel_next_s;

   // True when exactly one bit of v is set.
   function automatic logic is_onehot(input logic [NUM_SLV-1:0] v);
      logic seen;
      logic multi;
      seen  = 1'b0;
      multi = 1'b0;
      for (int i = 0; i < NUM_SLV; i++) begin
         if (v[i]) begin
            if (seen) begin
               multi = 1'b1;
            end else begin
               multi = multi;
            end
            seen = 1'b1;
         end else begin
            seen = seen;
         end
      end
      return seen & ~multi;
   endfunction

`ifdef APB_TIMEOUT_EN
   // Counter holds at most MAX_WAIT-1.
   localparam int CNT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;

   logic [CNT_W-1:0] wait_cnt_r;

   // Wait-state counter: cleared entering ACCESS, counts Pready=0 cycles.
   always_ff @(posedge Hclk or posedge Hreset) begin
      if (Hreset) begin
         wait_cnt_r <= {CNT_W{1'b0}};
      end else if (state_r == SETUP) begin
         wait_cnt_r <= {CNT_W{1'b0}};
      end else if ((state_r == ACCESS) && !Pready && !timeout_s) begin
         wait_cnt_r <= wait_cnt_r + 1'b1;
      end else begin
         wait_cnt_r <= wait_cnt_r;
      end
   end

   assign timeout_s = (wait_cnt_r == CNT_W'(MAX_WAIT - 1));
`else
   assign timeout_s = 1'b0;
`endif

   // Next-state decode and transfer acceptance.
   always_comb begin
      next_state_s = state_r;
      accept_s     = 1'b0;
      case (state_r)
         IDLE, ERR2: begin
            if (valid) begin
               accept_s = 1'b1;
               if (!is_onehot(slv_sel)) begin
                  next_state_s = ERR1;
               end else if (Hwrite) begin
                  next_state_s = WDATA;
               end else begin
                  next_state_s = SETUP;
               end
            end else begin
               next_state_s = IDLE;
            end
         end
         WDATA:  next_state_s = SETUP;
         SETUP:  next_state_s = ACCESS;
         ACCESS: begin
            // A Pready on the timeout edge still completes normally.
            if (Pready) begin
               if (Pslverr) begin
                  next_state_s = ERR1;
               end else begin
                  next_state_s = IDLE;
               end
            end else if (timeout_s) begin
               next_state_s = ERR1;
            end else begin
               next_state_s = ACCESS;
            end
         end
         ERR1:    next_state_s = ERR2;
         default: next_state_s = IDLE;
      endcase
   end

   assign sel_next_s = accept_s ? slv_sel : sel_r;
   assign apb_next_s = (next_state_s == SETUP) || (next_state_s == ACCESS);

   // State register.
   always_ff @(posedge Hclk or posedge Hreset) begin
      if (Hreset) begin
         state_r <= IDLE;
      end else begin
         state_r <= next_state_s;
      end
   end

   // Request capture: address, direction and select latched on acceptance.
   always_ff @(posedge Hclk or posedge Hreset) begin
      if (Hreset) begin
         sel_r  <= {NUM_SLV{1'b0}};
         Paddr  <= {ADDR_W{1'b0}};
         Pwrite <= 1'b0;
      end else if (accept_s) begin
         sel_r  <= slv_sel;
         Paddr  <= Haddr;
         Pwrite <= Hwrite;
      end else begin
         sel_r  <= sel_r;
         Paddr  <= Paddr;
         Pwrite <= Pwrite;
      end
   end

   // Write data arrives one cycle after the address and is held through APB.
   always_ff @(posedge Hclk or posedge Hreset) begin
      if (Hreset) begin
         Pwdata <= {DATA_W{1'b0}};
      end else if (state_r == WDATA) begin
         Pwdata <= Hwdata;
      end else begin
         Pwdata <= Pwdata;
      end
   end

   // Read data captured only on an error-free read completion.
   always_ff @(posedge Hclk or posedge Hreset) begin
      if (Hreset) begin
         Hrdata <= {DATA_W{1'b0}};
      end else if ((state_r == ACCESS) && Pready && !Pslverr && !Pwrite) begin
         Hrdata <= Prdata;
      end else begin
         Hrdata <= Hrdata;
      end
   end

   // Handshake outputs registered from the next state.
   always_ff @(posedge Hclk or posedge Hreset) begin
      if (Hreset) begin
         Hreadyout <= 1'b1;
         Hresp     <= 1'b0;
         Pselx     <= {NUM_SLV{1'b0}};
         Penable   <= 1'b0;
      end else begin
         Hreadyout <= (next_state_s == IDLE) || (next_state_s == ERR2);
         Hresp     <= (next_state_s == ERR1) || (next_state_s == ERR2);
         Pselx     <= apb_next_s ? sel_next_s : {NUM_SLV{1'b0}};
         Penable   <= (next_state_s == ACCESS);
      end
   end

endmodule
